// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding, fixed-latency data memory slave.
// Define DATA_MEM_MISALIGN_CHECK_EN to reject misaligned requests with resp_err_o.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_write_o,
  output logic                  resp_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rwrite_q, rwrite_d;
  logic                  rerr_q, rerr_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic addr_mis;
  logic commit;
  logic mem_we;
  logic unused_addr_bits;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign addr_mis = |req_addr_i[1:0];
`else
  assign addr_mis = 1'b0;
`endif

  // Byte offset and bits above the index never reach the array.
  assign unused_addr_bits =
    ^{req_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2],
      req_addr_i[1:0]};

  assign commit = (state_q == S_WAIT) &&
                  (cnt_q == '0);
  assign mem_we = commit && write_q && !mis_q;

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_write_o = rwrite_q;
  assign resp_err_o   = rerr_q;

  // Next-state: accept, count down, commit, then hold until handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    mis_d    = mis_q;
    rdata_d  = rdata_q;
    rwrite_d = rwrite_q;
    rerr_d   = rerr_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_valid_i) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY - 1);
          idx_d   = req_addr_i[ADDR_WIDTH+1:2];
          wdata_d = req_wdata_i;
          write_d = req_write_i;
          mis_d   = addr_mis;
        end
      end
      (state_q == S_WAIT): begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          rwrite_d = write_q;
          rerr_d   = mis_q;
          rdata_d  = (write_q || mis_q) ?
                     '0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == S_RESP): begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset abandons any pending access.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= '0;
      rwrite_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
      rwrite_q <= rwrite_d;
      rerr_q   <= rerr_d;
    end
  end

  // Array write at the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Default parameters: LATENCY=3, ADDR_WIDTH=10, DATA_WIDTH=32.
module tb_data_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_write_o;
  logic        resp_err_o;

  typedef struct {
    logic [31:0] rdata;
    logic        write;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  data_mem_responder dut (
    .clk          (clk),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_write_o (resp_write_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic misal(input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    return |a[1:0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk_exp(input logic w,
                                  input logic [31:0] a,
                                  input logic [31:0] d);
    exp_t e;
    e.write = w;
    e.err   = misal(a);
    e.rdata = (w || e.err) ? 32'h0 : model[a[11:2]];
    if (w && !e.err) model[a[11:2]] = d;
    return e;
  endfunction

  // One full transaction, entered and left at a negedge.
  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int stall);
    exp_t        e;
    int          lat;
    logic [31:0] hold;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req: got %b want 1", req_ready_o);
    end
    sb.push_back(mk_exp(w, a, d));
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_write_i = ~w;
    req_addr_i  = 32'hFFFF_FFFC;
    req_wdata_i = 32'hBAD0_BAD0;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL accept: ready got %b want 0", req_ready_o);
    end
    lat = 1;
    while (resp_valid_o !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT + 1) begin
      errors++;
      $display("FAIL latency a=%h: got %0d want %0d", a, lat - 1, LAT);
    end
    hold = resp_rdata_o;
    for (int i = 0; i < stall; i++) begin
      req_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== hold ||
          req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: v=%b d=%h rdy=%b want 1 %h 0",
                 i, resp_valid_o, resp_rdata_o, hold, req_ready_o);
      end
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty at response");
    end else begin
      e = sb.pop_front();
      if (resp_rdata_o !== e.rdata || resp_write_o !== e.write ||
          resp_err_o !== e.err) begin
        errors++;
        $display("FAIL resp a=%h: got %h/%b/%b want %h/%b/%b", a,
                 resp_rdata_o, resp_write_o, resp_err_o,
                 e.rdata, e.write, e.err);
      end
    end
    @(negedge clk);
    resp_ready_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL handshake: v=%b rdy=%b want 0 1",
               resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 ||
        resp_rdata_o !== 32'h0 || resp_write_o !== 1'b0 ||
        resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: v=%b rdy=%b d=%h w=%b e=%b want 0 1 0 0 0",
               resp_valid_o, req_ready_o, resp_rdata_o,
               resp_write_o, resp_err_o);
    end
    rst_n_i = 1'b1;
  endtask

  task automatic test_write_read();
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_stall();
    do_req(1'b0, 32'h10, 32'h0, 5);
  endtask

  task automatic test_wrap();
    do_req(1'b1, 32'h0, 32'h1, 0);
    do_req(1'b1, 32'h1000, 32'h2, 0);
    do_req(1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    int n;
    do_req(1'b1, 32'h20, 32'h0, 0);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h20;
    req_wdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_n_i     = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wait: rdy=%b v=%b want 1 0",
               req_ready_o, resp_valid_o);
    end
    @(negedge clk);
    rst_n_i = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 0);
    do_req(1'b1, 32'h30, 32'h5A5A_1234, 0);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h30;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (resp_valid_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_rdata_o !== 32'h5A5A_1234) begin
      errors++;
      $display("FAIL pre_rst_read: got %h want 5a5a1234", resp_rdata_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
        req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_resp: v=%b d=%h rdy=%b want 0 0 1",
               resp_valid_o, resp_rdata_o, req_ready_o);
    end
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  task automatic test_misalign();
    do_req(1'b1, 32'h20, 32'h600D_F00D, 0);
    do_req(1'b0, 32'h22, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic        ws [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] as [5] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40};
    logic [31:0] ds [5] = '{32'h1111_1111, 32'h0, 32'h2222_2222,
                            32'h0, 32'h0};
    int   acc [5];
    int   n_acc = 0;
    int   n_resp = 0;
    int   it = 0;
    exp_t e;
    resp_ready_i = 1'b1;
    while (n_resp < 5 && it < 200) begin
      if (resp_valid_o === 1'b1) begin
        n_resp++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb: empty at response %0d", n_resp);
        end else begin
          e = sb.pop_front();
          if (resp_rdata_o !== e.rdata || resp_write_o !== e.write ||
              resp_err_o !== e.err) begin
            errors++;
            $display("FAIL b2b_resp%0d: got %h/%b/%b want %h/%b/%b",
                     n_resp, resp_rdata_o, resp_write_o, resp_err_o,
                     e.rdata, e.write, e.err);
          end
        end
      end
      if (req_ready_o === 1'b1 && n_acc < 5) begin
        sb.push_back(mk_exp(ws[n_acc], as[n_acc], ds[n_acc]));
        req_valid_i = 1'b1;
        req_write_i = ws[n_acc];
        req_addr_i  = as[n_acc];
        req_wdata_i = ds[n_acc];
        acc[n_acc]  = cyc;
        n_acc++;
      end else begin
        req_valid_i = (n_acc < 5);
        req_write_i = 1'b1;
        req_addr_i  = 32'h40;
        req_wdata_i = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      it++;
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b0;
    checks++;
    if (n_resp != 5 || n_acc != 5) begin
      errors++;
      $display("FAIL b2b_count: acc=%0d resp=%0d want 5 5",
               n_acc, n_resp);
    end
    for (int i = 1; i < n_acc; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != LAT + 2) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d want %0d",
                 i, acc[i] - acc[i-1], LAT + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_wrap();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
